// File: rtl/simproc_ctrl_pkg.sv
// Shared types for the simproc host run controller.
// Op codes and response status codes are also used by host drivers and the bench.
package simproc_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_WRITE = 3'd0,
    OP_READ  = 3'd1,
    OP_SETPC = 3'd2,
    OP_RUN   = 3'd3,
    OP_STEP  = 3'd4,
    OP_STOP  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_HALT    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ILLEGAL = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOST_WR = 3'd1,
    S_HOST_RD = 3'd2,
    S_RUNNING = 3'd3,
    S_DRAIN   = 3'd4,
    S_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/simproc_host_ctrl_if.sv
// Host command / response bundle for simproc_host_ctrl.
//   cmd_valid/cmd_ready handshake with cmd_op, cmd_addr, cmd_data.
//   rsp_valid one-cycle pulse with rsp_status, rsp_data.
// master = host side, slave = controller side.
interface simproc_host_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_status, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_status, rsp_data
  );
endinterface

// File: rtl/simproc_mem_mux.sv
// Memory ownership select for the single-port 256x8 memory.
//   core_own      : 1 = core drives memory, 0 = host drives memory
//   host_*        : registered host-side address / data / write enable
//   proc_*        : core-side address / data / write enable
//   mem_*         : to memory
// The core write enable only reaches memory while the core owns it.
module simproc_mem_mux (
  input  logic       core_own,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_din,
  input  logic       host_we,
  input  logic [7:0] proc_addr,
  input  logic [7:0] proc_din,
  input  logic       proc_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_we
);

  always_comb begin
    if (core_own) begin
      mem_addr = proc_addr;
      mem_din  = proc_din;
      mem_we   = proc_we;
    end else begin
      mem_addr = host_addr;
      mem_din  = host_din;
      mem_we   = host_we;
    end
  end

endmodule

// File: rtl/simproc_host_ctrl.sv
// Host-side run controller for simproc.
//   clk, rst           : clock, synchronous active-high reset
//   host (slave)       : one-at-a-time command in, one response pulse per command
//   proc_mem_*         : core memory port (write gated unless core owns memory)
//   mem_*              : single-port 256x8 memory, mem_dout combinational
//   pc_set_val/_wr     : PC load to the core
//   run, halt, done    : core run enable, halt and instruction-complete
module simproc_host_ctrl
  import simproc_ctrl_pkg::*;
#(
  parameter int               CYC_W      = 16,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF,
  parameter int               DRAIN_MAX  = 16
) (
  input  logic                clk,
  input  logic                rst,
  simproc_host_ctrl_if.slave  host,
  input  logic [7:0]          proc_mem_addr,
  input  logic [7:0]          proc_mem_din,
  input  logic                proc_mem_we,
  output logic [7:0]          proc_mem_dout,
  output logic [7:0]          mem_addr,
  output logic [7:0]          mem_din,
  output logic                mem_we,
  input  logic [7:0]          mem_dout,
  output logic [7:0]          pc_set_val,
  output logic                pc_set_wr,
  output logic                run,
  input  logic                halt,
  input  logic                done
);

  localparam int               DRN_W    = $clog2(DRAIN_MAX + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = MAX_CYCLES - 1'b1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_MAX - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  status_e          rsp_status_q, rsp_status_d;
  logic             run_q, run_d;
  logic             step_mode_q, step_mode_d;
  logic [7:0]       step_tgt_q, step_tgt_d;
  logic [7:0]       retired_q, retired_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [7:0]       pc_set_val_q, pc_set_val_d;
  logic             pc_set_wr_q, pc_set_wr_d;
  logic [7:0]       host_addr_q, host_addr_d;
  logic [7:0]       host_din_q, host_din_d;
  logic             host_we_q, host_we_d;

  logic       cmd_ready;
  logic       accept;
  logic [7:0] retired_inc;
  logic       core_own;

  // STOP is the only command that can interrupt a run
  assign cmd_ready   = (state_q == S_IDLE) ||
                       ((state_q == S_RUNNING) && (host.cmd_op == OP_STOP));
  assign accept      = host.cmd_valid && cmd_ready;
  assign retired_inc = done ? sat_inc8(retired_q) : retired_q;
  assign core_own    = (state_q == S_RUNNING) || (state_q == S_DRAIN);

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    rsp_status_d = rsp_status_q;
    run_d        = run_q;
    step_mode_d  = step_mode_q;
    step_tgt_d   = step_tgt_q;
    retired_d    = retired_q;
    cyc_d        = cyc_q;
    drain_d      = drain_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    pc_set_val_d = pc_set_val_q;
    pc_set_wr_d  = 1'b0;
    host_addr_d  = host_addr_q;
    host_din_d   = host_din_q;
    host_we_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // default single-cycle reply; overridden for READ and real runs
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          rsp_data_d   = 8'd0;
          case (host.cmd_op)
            OP_WRITE: begin
              host_addr_d = host.cmd_addr;
              host_din_d  = host.cmd_data;
              host_we_d   = 1'b1;
              state_d     = S_HOST_WR;
            end
            OP_READ: begin
              rsp_valid_d = 1'b0;
              host_addr_d = host.cmd_addr;
              state_d     = S_HOST_RD;
            end
            OP_SETPC: begin
              pc_set_val_d = host.cmd_data;
              pc_set_wr_d  = 1'b1;
            end
            OP_RUN, OP_STEP: begin
              // a zero-length step answers at once and never raises run
              if (!((host.cmd_op == OP_STEP) && (host.cmd_data == 8'd0))) begin
                rsp_valid_d = 1'b0;
                run_d       = 1'b1;
                step_mode_d = (host.cmd_op == OP_STEP);
                step_tgt_d  = host.cmd_data;
                retired_d   = 8'd0;
                cyc_d       = '0;
                drain_d     = '0;
                status_d    = ST_OK;
                state_d     = S_RUNNING;
              end
            end
            OP_STOP: ;
            default: rsp_status_d = ST_ILLEGAL;
          endcase
        end
      end

      S_HOST_WR: state_d = S_IDLE;

      S_HOST_RD: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = ST_OK;
        rsp_data_d   = mem_dout;
        state_d      = S_IDLE;
      end

      S_RUNNING: begin
        retired_d = retired_inc;
        cyc_d     = cyc_q + 1'b1;
        if (halt || (step_mode_q && done && (retired_inc == step_tgt_q))) begin
          run_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = halt ? ST_HALT : ST_OK;
          rsp_data_d   = retired_inc;
          state_d      = S_RESP;
        end else if (accept) begin
          status_d = ST_OK;
          drain_d  = '0;
          state_d  = S_DRAIN;
        end else if (cyc_q == CYC_LAST) begin
          status_d = ST_TIMEOUT;
          drain_d  = '0;
          state_d  = S_DRAIN;
        end
      end

      S_DRAIN: begin
        retired_d = retired_inc;
        drain_d   = drain_q + 1'b1;
        if (halt || done || (drain_q == DRN_LAST)) begin
          run_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = retired_inc;
          state_d      = S_RESP;
          if (halt)
            rsp_status_d = ST_HALT;
          else if (done)
            rsp_status_d = status_q;
          else
            rsp_status_d = ST_TIMEOUT;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: begin
        run_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      status_q     <= ST_OK;
      rsp_status_q <= ST_OK;
      run_q        <= 1'b0;
      step_mode_q  <= 1'b0;
      step_tgt_q   <= 8'd0;
      retired_q    <= 8'd0;
      cyc_q        <= '0;
      drain_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'd0;
      pc_set_val_q <= 8'd0;
      pc_set_wr_q  <= 1'b0;
      host_addr_q  <= 8'd0;
      host_din_q   <= 8'd0;
      host_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      rsp_status_q <= rsp_status_d;
      run_q        <= run_d;
      step_mode_q  <= step_mode_d;
      step_tgt_q   <= step_tgt_d;
      retired_q    <= retired_d;
      cyc_q        <= cyc_d;
      drain_q      <= drain_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      pc_set_val_q <= pc_set_val_d;
      pc_set_wr_q  <= pc_set_wr_d;
      host_addr_q  <= host_addr_d;
      host_din_q   <= host_din_d;
      host_we_q    <= host_we_d;
    end
  end

  simproc_mem_mux u_mem_mux (
    .core_own  (core_own),
    .host_addr (host_addr_q),
    .host_din  (host_din_q),
    .host_we   (host_we_q),
    .proc_addr (proc_mem_addr),
    .proc_din  (proc_mem_din),
    .proc_we   (proc_mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we)
  );

  assign host.cmd_ready  = cmd_ready;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp_status = rsp_status_q;
  assign host.rsp_data   = rsp_data_q;
  assign proc_mem_dout   = mem_dout;
  assign pc_set_val      = pc_set_val_q;
  assign pc_set_wr       = pc_set_wr_q;
  assign run             = run_q;

endmodule

// File: tb/tb_simproc_host_ctrl.sv
// Self-checking bench for simproc_host_ctrl: directed cases plus a randomized
// command mix, checked against a command-level model of memory and run outcomes.
module tb_simproc_host_ctrl;
  import simproc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] proc_mem_addr, proc_mem_din, proc_mem_dout;
  logic       proc_mem_we;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic       mem_we;
  logic [7:0] pc_set_val;
  logic       pc_set_wr, run, halt, done;

  int n_chk = 0;
  int n_fail = 0;

  // core emulation knobs
  int core_period = 0;
  int core_halt_k = 0;
  int core_done_at = 0;

  // reference model state
  logic [7:0] ref_mem [256];
  logic [7:0] wr_addrs [$];

  // bench-side memory
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  simproc_host_ctrl_if hif ();

  simproc_host_ctrl #(
    .CYC_W      (16),
    .MAX_CYCLES (16'd20),
    .DRAIN_MAX  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (hif),
    .proc_mem_addr (proc_mem_addr),
    .proc_mem_din  (proc_mem_din),
    .proc_mem_we   (proc_mem_we),
    .proc_mem_dout (proc_mem_dout),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_we        (mem_we),
    .mem_dout      (mem_dout),
    .pc_set_val    (pc_set_val),
    .pc_set_wr     (pc_set_wr),
    .run           (run),
    .halt          (halt),
    .done          (done)
  );

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  // core model: done every core_period run cycles and/or at run cycle core_done_at,
  // halt coincident with the core_halt_k-th done
  initial begin
    int rc, nd;
    rc = 0; nd = 0; done = 1'b0; halt = 1'b0;
    forever begin
      @(negedge clk);
      if (run === 1'b1) begin
        rc++;
        done = ((core_period != 0) && (rc % core_period == 0)) || (rc == core_done_at);
        if (done) nd++;
        halt = done && (core_halt_k != 0) && (nd == core_halt_k);
      end else begin
        rc = 0; nd = 0; done = 1'b0; halt = 1'b0;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // present a command; returns at +1 of the cycle after acceptance
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    hif.cmd_valid = 1'b1; hif.cmd_op = op; hif.cmd_addr = a; hif.cmd_data = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1;
      if (hif.cmd_ready === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    hif.cmd_valid = 1'b0;
    if (!acc) chk_eq("accept_wait", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send(OP_WRITE, a, d);
    chk_eq("wr_we", mem_we, 1);
    chk_eq("wr_addr", mem_addr, a);
    chk_eq("wr_din", mem_din, d);
    chk_eq("wr_rsp", hif.rsp_valid, 1);
    chk_eq("wr_status", hif.rsp_status, ST_OK);
    ref_mem[a] = d;
    wr_addrs.push_back(a);
    tick();
    chk_eq("wr_we_off", mem_we, 0);
    chk_eq("wr_rsp_off", hif.rsp_valid, 0);
  endtask

  task automatic do_read(input logic [7:0] a);
    send(OP_READ, a, 8'd0);
    chk_eq("rd_addr", mem_addr, a);
    chk_eq("rd_pdout", proc_mem_dout, ref_mem[a]);
    chk_eq("rd_rsp_early", hif.rsp_valid, 0);
    tick();
    chk_eq("rd_rsp", hif.rsp_valid, 1);
    chk_eq("rd_status", hif.rsp_status, ST_OK);
    chk_eq("rd_data", hif.rsp_data, ref_mem[a]);
  endtask

  task automatic do_setpc(input logic [7:0] v);
    send(OP_SETPC, 8'd0, v);
    chk_eq("pc_wr", pc_set_wr, 1);
    chk_eq("pc_val", pc_set_val, v);
    chk_eq("pc_rsp", hif.rsp_valid, 1);
    chk_eq("pc_status", hif.rsp_status, ST_OK);
    tick();
    chk_eq("pc_wr_off", pc_set_wr, 0);
    chk_eq("pc_val_hold", pc_set_val, v);
  endtask

  task automatic do_illegal(input logic [2:0] op);
    send(op, 8'h5A, 8'hC3);
    chk_eq("ill_rsp", hif.rsp_valid, 1);
    chk_eq("ill_status", hif.rsp_status, ST_ILLEGAL);
    chk_eq("ill_we", mem_we, 0);
    chk_eq("ill_pc_wr", pc_set_wr, 0);
    chk_eq("ill_run", run, 0);
  endtask

  // RUN/STEP with expected outcome: status, retired count, run-high cycles
  task automatic do_exec(input logic [2:0] op, input logic [7:0] d, input int period,
                         input int halt_k, input int done_at, input int stop_at,
                         input int poke_at, input logic [1:0] exp_st,
                         input logic [7:0] exp_data, input int exp_len);
    int   len;
    logic got;
    core_period = period; core_halt_k = halt_k; core_done_at = done_at;
    len = 0; got = 1'b0;
    send(op, 8'd0, d);
    for (int i = 1; i <= 300 && !got; i++) begin
      if (hif.rsp_valid === 1'b1) begin
        got = 1'b1;
        chk_eq("ex_status", hif.rsp_status, exp_st);
        chk_eq("ex_data", hif.rsp_data, exp_data);
        chk_eq("ex_runlen", len, exp_len);
        chk_eq("ex_run_low", run, 0);
      end else begin
        if (run === 1'b1) len++;
        if (i == poke_at) begin
          hif.cmd_valid = 1'b1; hif.cmd_op = OP_WRITE; hif.cmd_addr = 8'h77; hif.cmd_data = 8'h99;
          #1;
          chk_eq("hold_ready", hif.cmd_ready, 0);
          hif.cmd_valid = 1'b0;
        end
        if (i == stop_at) begin
          hif.cmd_valid = 1'b1; hif.cmd_op = OP_STOP;
          #1;
          chk_eq("stop_ready", hif.cmd_ready, 1);
        end
        @(posedge clk); #1;
        hif.cmd_valid = 1'b0;
      end
    end
    if (!got) chk_eq("rsp_wait", {31'd0, got}, 32'd1);
    tick();
    chk_eq("ex_rsp_off", hif.rsp_valid, 0);
    if (exp_len > 0) begin
      ref_mem[8'hFF] = 8'hA5;
      wr_addrs.push_back(8'hFF);
    end
    core_period = 0; core_halt_k = 0; core_done_at = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   n, p, k, sel;
    rst = 1'b1;
    hif.cmd_valid = 1'b0; hif.cmd_op = 3'd0; hif.cmd_addr = 8'd0; hif.cmd_data = 8'd0;
    // core constantly tries to write 0xA5 to 0xFF; only lands while it owns memory
    proc_mem_addr = 8'hFF; proc_mem_din = 8'hA5; proc_mem_we = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_run", run, 0);
    chk_eq("rst_rsp", hif.rsp_valid, 0);
    chk_eq("rst_status", hif.rsp_status, 0);
    chk_eq("rst_data", hif.rsp_data, 0);
    chk_eq("rst_pc_val", pc_set_val, 0);
    chk_eq("rst_pc_wr", pc_set_wr, 0);
    chk_eq("rst_we", mem_we, 0);
    chk_eq("rst_addr", mem_addr, 0);
    chk_eq("rst_ready", hif.cmd_ready, 1);
    rst = 1'b0;
    tick();

    do_write(8'h00, 8'h44);
    do_read(8'h00);
    do_setpc(8'h10);
    do_exec(OP_STEP, 8'd3, 4, 0, 0, 0, 2, ST_OK, 8'd3, 12);
    do_exec(OP_RUN, 8'd0, 3, 5, 0, 0, 0, ST_HALT, 8'd5, 15);
    do_exec(OP_RUN, 8'd0, 0, 0, 0, 0, 0, ST_TIMEOUT, 8'd0, 36);
    do_exec(OP_RUN, 8'd0, 0, 0, 5, 3, 0, ST_OK, 8'd1, 5);
    do_exec(OP_STEP, 8'd0, 1, 0, 0, 0, 0, ST_OK, 8'd0, 0);
    do_read(8'hFF);
    do_illegal(3'd7);
    do_illegal(3'd6);

    // reset in the middle of a run
    send(OP_RUN, 8'd0, 8'd0);
    repeat (3) tick();
    chk_eq("mid_run_high", run, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("mid_rst_run", run, 0);
    chk_eq("mid_rst_rsp", hif.rsp_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (hif.rsp_valid === 1'b1) seen = 1'b1;
    end
    chk_eq("mid_rst_no_rsp", {31'd0, seen}, 0);
    ref_mem[8'hFF] = 8'hA5;

    // randomized command mix
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0, 1: do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        2: if (wr_addrs.size() > 0)
             do_read(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
        3: do_setpc(8'($urandom_range(0, 255)));
        4: begin
          n = int'($urandom_range(1, 4));
          p = int'($urandom_range(1, 4));
          do_exec(OP_STEP, 8'(n), p, 0, 0, 0, 0, ST_OK, 8'(n), n * p);
        end
        5: begin
          k = int'($urandom_range(1, 5));
          p = int'($urandom_range(1, 3));
          do_exec(OP_RUN, 8'd0, p, k, 0, 0, 0, ST_HALT, 8'(k), k * p);
        end
        default: do_illegal(3'($urandom_range(6, 7)));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/simproc_host_ctrl.md
Name: simproc_host_ctrl

Overview:
Host-side run controller for simproc. It accepts one command at a time to load and read program memory, set the PC, and run or single-step the core. It arbitrates the single-port 8-bit memory between the host and the core, and reports completion status. It sits between a host/debug command interface, simproc, and the 256x8 memory.

Parameters:
CYC_W, 16, width of the run-cycle budget counter
MAX_CYCLES, 16'hFFFF, cycles allowed in RUNNING before forced stop
DRAIN_MAX, 16, cycles allowed in DRAIN waiting for done/halt

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller accepts command this cycle
cmd_op  in  3  0 WRITE, 1 READ, 2 SETPC, 3 RUN, 4 STEP, 5 STOP, 6-7 illegal
cmd_addr  in  8  memory address (WRITE/READ)
cmd_data  in  8  write data / PC value / step count
rsp_valid  out  1  one-cycle response pulse
rsp_status  out  2  0 OK, 1 HALT, 2 TIMEOUT, 3 ILLEGAL
rsp_data  out  8  read data, or instructions retired (RUN/STEP)
proc_mem_addr  in  8  core memory address
proc_mem_din  in  8  core write data
proc_mem_we  in  1  core write enable
proc_mem_dout  out  8  read data to core (= mem_dout, always)
mem_addr  out  8  to memory
mem_din  out  8  to memory
mem_we  out  1  to memory
mem_dout  in  8  combinational memory read data
pc_set_val  out  8  PC load value
pc_set_wr  out  1  PC load strobe
run  out  1  core run enable
halt  in  1  core executed halt
done  in  1  core instruction-complete pulse

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-run drops run at the next edge; no response is issued for the aborted command.
- States: IDLE, HOST_WR, HOST_RD, RUNNING, DRAIN, RESP.
- cmd_ready = 1 only in IDLE, or in RUNNING when cmd_op==STOP. A command is accepted when cmd_valid && cmd_ready. Every accepted command produces exactly one rsp_valid pulse.
- Memory ownership: the core owns memory in RUNNING and DRAIN (mem_* = proc_*). Otherwise the host owns it, and proc_mem_we is gated to 0.
- WRITE accepted at cycle N: in N+1, mem_addr=cmd_addr, mem_din=cmd_data, mem_we=1, rsp_valid=1, status OK.
- READ accepted at N: mem_addr=cmd_addr in N+1; rsp_valid in N+2 with rsp_data = mem_dout sampled in N+1.
- SETPC at N: pc_set_val=cmd_data and pc_set_wr=1 for exactly cycle N+1; rsp OK in N+1. pc_set_val holds afterwards.
- RUN at N: run=1 from N+1. Retired count (saturating at 255) and cycle count are cleared on entry.
- STEP at N: as RUN, with step target = cmd_data. cmd_data==0 gives rsp OK, data 0 in N+1, and run never rises.
- In RUNNING, each done pulse increments retired.
  - STEP target reached: enter RESP with status OK; run drops the same edge.
  - halt=1: run drops next edge, status HALT. If halt and done are in the same cycle, the done is counted and HALT wins.
  - Cycle count reaching MAX_CYCLES: go to DRAIN, status TIMEOUT. halt in the same cycle takes priority.
  - STOP accepted: go to DRAIN, status OK.
- DRAIN: run stays 1 until done or halt is seen, then run=0 and go to RESP. A done in DRAIN is counted. If neither arrives within DRAIN_MAX cycles, run is forced to 0 with status TIMEOUT.
- RESP: rsp_valid=1 for one cycle, rsp_data = retired; then return to IDLE.
- Illegal op (6, 7) in IDLE: rsp ILLEGAL in N+1, no side effects.
- The core is never granted memory and run in the same cycle as a host write.

Decomposition:
- simproc_ctrl_pkg: op_e (3-bit), status_e (2-bit), state_e, and OP_*/ST_* constants shared with host drivers and the bench.
- One sub-module, simproc_mem_mux: ownership select plus write-enable gating.

Test Plan:
- WRITE addr 0x00 data 0x44, then READ 0x00 -> mem_we pulse at N+1; READ rsp at N+2 with data 0x44, status OK.
- SETPC 0x10 -> pc_set_wr high exactly one cycle with pc_set_val=0x10; rsp OK.
- STEP 3, bench pulses done every 4 cycles -> run high ~12 cycles then falls; rsp OK, data 3; a host WRITE issued during the step is held (cmd_ready=0).
- RUN, halt after 5 done pulses (halt coincident with 5th done) -> rsp HALT, data 5; run low the next cycle.
- RUN with MAX_CYCLES=20, done never asserted -> DRAIN for DRAIN_MAX cycles, then run=0; rsp TIMEOUT, data 0.
- STOP during RUN followed by done 2 cycles later -> rsp OK; rst asserted mid-RUN -> run=0 and rsp_valid=0 next cycle; cmd_op=7 -> rsp ILLEGAL.
